// File: rtl/checkpoint_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : checkpoint_scoreboard
//  Purpose  : Run-checker for the pipelined CPU bench. Grades a table of
//             (num_inst, expected output_port) checkpoints against the CPU
//             debug outputs and ends the run on halt, timeout or first fail.
//  Options  : SCOREBOARD_STOP_ON_FAIL_EN - end the run on the first Wrong grade
//  Revision : 1.0 - initial release
// ============================================================================
module checkpoint_scoreboard #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_TEST   = 64,
    parameter int IDX_W      = 6,
    parameter int CYCLE_W    = 16,
    parameter int MAX_CYCLES = 10000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WORD_SIZE-1:0] cfg_num_inst,
    input  logic [WORD_SIZE-1:0] cfg_ans,
    input  logic [IDX_W:0]       cfg_len,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [1:0]           rd_result,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           finish_cause,
    output logic [IDX_W:0]       pass_count,
    output logic [IDX_W:0]       fail_count,
    output logic [IDX_W:0]       miss_count,
    output logic [IDX_W-1:0]     first_fail,
    output logic [CYCLE_W-1:0]   num_clock
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int                 c_depth      = 1 << IDX_W;
    localparam logic [IDX_W:0]     c_num_test   = (IDX_W + 1)'(NUM_TEST);
    localparam logic [CYCLE_W-1:0] c_max_cycles = CYCLE_W'(MAX_CYCLES);
    localparam logic [CYCLE_W-1:0] c_timeout_at = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W:0]     c_one        = (IDX_W + 1)'(1);

    localparam logic [1:0] c_res_none   = 2'b00;
    localparam logic [1:0] c_res_pass   = 2'b01;
    localparam logic [1:0] c_res_wrong  = 2'b10;

    localparam logic [1:0] c_cause_halt    = 2'd0;
    localparam logic [1:0] c_cause_timeout = 2'd1;
    localparam logic [1:0] c_cause_fail    = 2'd2;

    // Checkpoint table: deliberately not reset so a run can be repeated
    logic [WORD_SIZE-1:0] r_tbl_num_inst [c_depth];
    logic [WORD_SIZE-1:0] r_tbl_ans      [c_depth];

    logic [c_depth-1:0][1:0] r_result;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W:0]       r_len;
    logic [IDX_W:0]       r_ptr;
    logic [IDX_W:0]       r_pass_count;
    logic [IDX_W:0]       r_fail_count;
    logic [IDX_W:0]       r_miss_count;
    logic [IDX_W-1:0]     r_first_fail;
    logic [1:0]           r_finish_cause;
    logic [CYCLE_W-1:0]   r_num_clock;

    logic                 w_run;
    logic                 w_start;
    logic                 w_active;
    logic [IDX_W-1:0]     w_cur_idx;
    logic [WORD_SIZE-1:0] w_cur_num_inst;
    logic [WORD_SIZE-1:0] w_cur_ans;
    logic                 w_hit;
    logic                 w_skip;
    logic                 w_pass;
    logic                 w_wrong;
    logic [IDX_W:0]       w_ptr_nxt;
    logic                 w_stop_fail;
    logic                 w_halt;
    logic                 w_timeout;
    logic                 w_finish;
    logic [1:0]           w_cause;
    logic                 w_cfg_in_range;
    logic                 w_rd_in_range;

    assign w_run          = (r_state == S_RUN);
    assign w_start        = start && !w_run;
    assign w_cfg_in_range = ({1'b0, cfg_idx} < c_num_test);
    assign w_rd_in_range  = ({1'b0, rd_idx} < c_num_test);

    // Grading of the entry under the pointer; at most one entry per cycle
    assign w_active       = w_run && (r_ptr < r_len);
    assign w_cur_idx      = r_ptr[IDX_W-1:0];
    assign w_cur_num_inst = r_tbl_num_inst[w_cur_idx];
    assign w_cur_ans      = r_tbl_ans[w_cur_idx];
    assign w_hit          = w_active && (num_inst == w_cur_num_inst);
    assign w_skip         = w_active && (num_inst > w_cur_num_inst);
    assign w_pass         = w_hit && (output_port == w_cur_ans);
    assign w_wrong        = w_hit && (output_port != w_cur_ans);
    assign w_ptr_nxt      = (w_hit || w_skip) ? (r_ptr + c_one) : r_ptr;

`ifdef SCOREBOARD_STOP_ON_FAIL_EN
    assign w_stop_fail = w_wrong;
`else
    assign w_stop_fail = 1'b0;
`endif

    assign w_halt    = w_run && is_halted;
    assign w_timeout = w_run && (r_num_clock == c_timeout_at);
    assign w_finish  = w_stop_fail || w_halt || w_timeout;

    always_comb begin
        w_cause = c_cause_timeout;
        if (w_stop_fail) begin
            w_cause = c_cause_fail;
        end else if (w_halt) begin
            w_cause = c_cause_halt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)    w_state_nxt = S_RUN;
            S_RUN:   if (w_finish) w_state_nxt = S_DONE;
            S_DONE:  if (start)    w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cfg_we && !w_run && w_cfg_in_range) begin
            r_tbl_num_inst[cfg_idx] <= cfg_num_inst;
            r_tbl_ans[cfg_idx]      <= cfg_ans;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_ptr          <= '0;
            r_pass_count   <= '0;
            r_fail_count   <= '0;
            r_miss_count   <= '0;
            r_first_fail   <= '0;
            r_finish_cause <= '0;
            r_num_clock    <= '0;
            r_result       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_len          <= (cfg_len > c_num_test) ? c_num_test : cfg_len;
                r_ptr          <= '0;
                r_pass_count   <= '0;
                r_fail_count   <= '0;
                r_miss_count   <= '0;
                r_first_fail   <= '0;
                r_finish_cause <= '0;
                r_num_clock    <= '0;
                r_result       <= '0;
            end else if (w_run) begin
                r_ptr <= w_ptr_nxt;
                if (r_num_clock != c_max_cycles) begin
                    r_num_clock <= r_num_clock + CYCLE_W'(1);
                end
                if (w_hit) begin
                    r_result[w_cur_idx] <= w_pass ? c_res_pass : c_res_wrong;
                end
                if (w_pass) begin
                    r_pass_count <= r_pass_count + c_one;
                end
                if (w_wrong) begin
                    r_fail_count <= r_fail_count + c_one;
                    if (r_fail_count == '0) begin
                        r_first_fail <= w_cur_idx;
                    end
                end
                // Entries never reached are booked as misses on the way out
                if (w_finish) begin
                    r_finish_cause <= w_cause;
                    r_miss_count   <= r_miss_count + (w_skip ? c_one : '0)
                                      + (r_len - w_ptr_nxt);
                end else if (w_skip) begin
                    r_miss_count <= r_miss_count + c_one;
                end
            end
        end
    end

    assign rd_result    = w_rd_in_range ? r_result[rd_idx] : c_res_none;
    assign busy         = (r_state == S_RUN);
    assign done         = (r_state == S_DONE);
    assign finish_cause = r_finish_cause;
    assign pass_count   = r_pass_count;
    assign fail_count   = r_fail_count;
    assign miss_count   = r_miss_count;
    assign first_fail   = r_first_fail;
    assign num_clock    = r_num_clock;

endmodule
`default_nettype wire
